alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised multi-cycle ALU for the RV32 core. Executes the base integer ops in 1 cycle and RV32M
//  multiply/divide/remainder iteratively, one bit per cycle. Sits in EX behind a valid/ready handshake,
//  so the pipeline stalls on in_ready=0 or out_valid=1 && out_ready=0. One operation in flight at a time.
// PARAMETERS
//  DATA_WIDTH     32  operand/result width in bits; must be >= 4 and a power of 2
//  OPCODE_LENGTH  5   Operation width; bit 4 selects the M-extension group
//  ENABLE_M       1   0: M opcodes behave as undefined ops (result 0, 1-cycle latency)
// PORTS
//  clk        in   1              clock, all state updates on rising edge
//  reset      in   1              synchronous, active-high
//  in_valid   in   1              operands and Operation are valid
//  in_ready   out  1              block is idle and will accept
//  SrcA       in   DATA_WIDTH     operand A (dividend / multiplicand)
//  SrcB       in   DATA_WIDTH     operand B (divisor / multiplier / shift amount)
//  Operation  in   OPCODE_LENGTH  operation select, see encoding below
//  out_valid  out  1              ALUResult/Zero are valid
//  out_ready  in   1              consumer takes result
//  ALUResult  out  DATA_WIDTH     registered result
//  Zero       out  1              registered (ALUResult == 0)
// BEHAVIOUR
//  Encoding: 00000 AND | 00001 XOR | 00010 ADD | 00101 OR | 00110 SLL | 00111 SRA | 01000 EQ | 01010 SUB
//   | 01100 SLT (signed) | 10000 MUL | 10001 MULH (s*s) | 10010 MULHU | 10011 DIV | 10100 DIVU
//   | 10101 REM | 10110 REMU. Any other code is undefined: result 0.
//  Shifts use SrcB[$clog2(DATA_WIDTH)-1:0] only. SRA is arithmetic. EQ/SLT give 1 or 0, zero-extended.
//  Add/sub wrap modulo 2^DATA_WIDTH. No flags besides Zero.
//  MUL returns the low DATA_WIDTH bits; MULH/MULHU return the high DATA_WIDTH bits of the 2*DATA_WIDTH product.
//  Division truncates toward zero. REM takes the sign of the dividend.
//  Division by 0: quotient = all ones, remainder = SrcA.
//  Signed overflow (min / -1): quotient = min, remainder = 0.
//  FSM states:
//   IDLE: in_ready=1. An accept happens on an edge with in_valid=1. The block latches the operands and
//     Operation. Base/undefined op -> result computed and registered, go to DONE. M op (with ENABLE_M=1)
//     -> load iteration registers and count=0, go to CALC.
//   CALC: in_ready=0. One shift-add or restoring-subtract step per cycle on magnitudes; count++.
//     After DATA_WIDTH steps, apply the sign fix-up and special cases, register the result, go to DONE.
//   DONE: out_valid=1, in_ready=0. ALUResult and Zero stay stable until out_ready=1, then go to IDLE.
//     in_valid is ignored in DONE.
//  Latency, from the accept edge to the first cycle with out_valid=1:
//   base op: 1 cycle. M op: DATA_WIDTH+1 cycles, fixed, including the special cases.
//  Back-to-back: with out_ready held high, a new accept happens no earlier than 1 cycle after DONE exits.
//  Inputs are sampled only at accept. Changing SrcA/SrcB/Operation during CALC/DONE has no effect.
//  Reset (any state, including mid-CALC): next state IDLE, in-flight op discarded, out_valid=0,
//   ALUResult=0, Zero=1, count=0. in_ready=1 from the first cycle after reset deasserts.
//  All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
// TESTING
//  T1 ADD 7+5, out_ready=1 -> out_valid one cycle after accept, ALUResult=12, Zero=0; SUB 5-5 -> 0, Zero=1.
//  T2 SRA 0x80000000 by SrcB=0x24 (uses 4) -> 0xF8000000; SLT -1<1 -> 1; SLL 1 by 31 -> 0x80000000.
//  T3 MUL 0xFFFFFFFF*0xFFFFFFFF -> 1; MULH same -> 0; MULHU same -> 0xFFFFFFFE.
//     out_valid exactly 33 cycles after accept.
//  T4 DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF, REMU 7/0 -> 7;
//     DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//  T5 hold out_ready=0 for 10 cycles in DONE with a changing in_valid/SrcA -> result stable, in_ready=0.
//     Release -> IDLE next cycle.
//  T6 assert reset at CALC count=10 -> next cycle IDLE, out_valid=0, ALUResult=0; a new ADD completes normally.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: RV32 EX-stage ALU with single-cycle base ops and
// iterative one-bit-per-cycle RV32M multiply/divide.
module alu_seq #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5,
    parameter bit ENABLE_M      = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     Zero
);
    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(DATA_WIDTH);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND   = 5'b00000;
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR   = 5'b00001;
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD   = 5'b00010;
    localparam logic [OPCODE_LENGTH-1:0] OP_OR    = 5'b00101;
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL   = 5'b00110;
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA   = 5'b00111;
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ    = 5'b01000;
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB   = 5'b01010;
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT   = 5'b01100;
    localparam logic [OPCODE_LENGTH-1:0] OP_MUL   = 5'b10000;
    localparam logic [OPCODE_LENGTH-1:0] OP_MULH  = 5'b10001;
    localparam logic [OPCODE_LENGTH-1:0] OP_MULHU = 5'b10010;
    localparam logic [OPCODE_LENGTH-1:0] OP_DIV   = 5'b10011;
    localparam logic [OPCODE_LENGTH-1:0] OP_DIVU  = 5'b10100;
    localparam logic [OPCODE_LENGTH-1:0] OP_REM   = 5'b10101;
    localparam logic [OPCODE_LENGTH-1:0] OP_REMU  = 5'b10110;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [OPCODE_LENGTH-1:0] op_q, op_d;
    logic [W-1:0]             a_q, a_d, b_q, b_d;
    logic [W-1:0]             hi_q, hi_d, lo_q, lo_d;
    logic [W-1:0]             res_q, res_d;
    logic                     zero_q, zero_d;
    logic [CW-1:0]            cnt_q, cnt_d;

    logic [W:0]   mul_sum, div_sh, div_tr;
    logic [W-1:0] ma, mb, hi_n, lo_n, m_res;
    logic         sgn_q, neg_q;

    function automatic logic is_mul(input logic [OPCODE_LENGTH-1:0] op);
        return op == OP_MUL || op == OP_MULH || op == OP_MULHU;
    endfunction

    function automatic logic is_sgn(input logic [OPCODE_LENGTH-1:0] op);
        return op == OP_MULH || op == OP_DIV || op == OP_REM;
    endfunction

    function automatic logic is_m(input logic [OPCODE_LENGTH-1:0] op);
        return ENABLE_M && (is_mul(op) || op == OP_DIV || op == OP_DIVU
                            || op == OP_REM || op == OP_REMU);
    endfunction

    function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic s);
        return (s && v[W-1]) ? -v : v;
    endfunction

    function automatic logic [W-1:0] base_op(
        input logic [OPCODE_LENGTH-1:0] op,
        input logic [W-1:0]             a,
        input logic [W-1:0]             b
    );
        logic [SW-1:0] sh;
        sh = b[SW-1:0];
        case (op)
            OP_AND:  return a & b;
            OP_XOR:  return a ^ b;
            OP_ADD:  return a + b;
            OP_OR:   return a | b;
            OP_SLL:  return a << sh;
            OP_SRA:  return $signed(a) >>> sh;
            OP_EQ:   return {{(W-1){1'b0}}, a == b};
            OP_SUB:  return a - b;
            OP_SLT:  return {{(W-1){1'b0}}, $signed(a) < $signed(b)};
            default: return '0;
        endcase
    endfunction

    assign sgn_q = is_sgn(op_q);
    assign ma    = mag(a_q, sgn_q);
    assign mb    = mag(b_q, sgn_q);

    // One shift-add (multiply) or restoring-subtract (divide) step on magnitudes
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, ma} : '0);
        div_sh  = {hi_q, lo_q[W-1]};
        div_tr  = div_sh - {1'b0, mb};
        if (is_mul(op_q)) begin
            hi_n = mul_sum[W:1];
            lo_n = {mul_sum[0], lo_q[W-1:1]};
        end else begin
            hi_n = div_tr[W] ? div_sh[W-1:0] : div_tr[W-1:0];
            lo_n = {lo_q[W-2:0], ~div_tr[W]};
        end
    end

    // Sign fix-up and divide-by-zero handling applied to the final step
    always_comb begin
        neg_q = sgn_q && (a_q[W-1] ^ b_q[W-1]);
        m_res = '0;
        case (op_q)
            OP_MUL:   m_res = lo_n;
            OP_MULHU: m_res = hi_n;
            OP_MULH:  m_res = neg_q ? (~hi_n + {{(W-1){1'b0}}, lo_n == '0}) : hi_n;
            OP_DIV,
            OP_DIVU:  m_res = (b_q == '0) ? '1 : (neg_q ? -lo_n : lo_n);
            OP_REM,
            OP_REMU:  m_res = (b_q == '0) ? a_q
                            : ((sgn_q && a_q[W-1]) ? -hi_n : hi_n);
            default:  m_res = '0;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = is_m(Operation) ? S_CALC : S_DONE;
            S_CALC:  if (cnt_q == LAST) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state only
    always_comb begin
        in_ready  = state_q == S_IDLE;
        out_valid = state_q == S_DONE;
    end

    // Datapath next values: latch on accept, iterate in CALC, hold otherwise
    always_comb begin
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        res_d  = res_q;
        zero_d = zero_q;
        cnt_d  = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d  = Operation;
                    a_d   = SrcA;
                    b_d   = SrcB;
                    hi_d  = '0;
                    cnt_d = '0;
                    lo_d  = is_mul(Operation) ? mag(SrcB, is_sgn(Operation))
                                              : mag(SrcA, is_sgn(Operation));
                    if (!is_m(Operation)) begin
                        res_d  = base_op(Operation, SrcA, SrcB);
                        zero_d = res_d == '0;
                    end
                end
            end
            S_CALC: begin
                hi_d  = hi_n;
                lo_d  = lo_n;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    res_d  = m_res;
                    zero_d = m_res == '0;
                end
            end
            default: ;
        endcase
    end

    assign ALUResult = res_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against an
// arithmetic reference model with a per-cycle output monitor.
module tb_alu_seq;
    localparam int W = 32;

    localparam logic [4:0] OP_AND   = 5'b00000;
    localparam logic [4:0] OP_XOR   = 5'b00001;
    localparam logic [4:0] OP_ADD   = 5'b00010;
    localparam logic [4:0] OP_OR    = 5'b00101;
    localparam logic [4:0] OP_SLL   = 5'b00110;
    localparam logic [4:0] OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_EQ    = 5'b01000;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SLT   = 5'b01100;
    localparam logic [4:0] OP_MUL   = 5'b10000;
    localparam logic [4:0] OP_MULH  = 5'b10001;
    localparam logic [4:0] OP_MULHU = 5'b10010;
    localparam logic [4:0] OP_DIV   = 5'b10011;
    localparam logic [4:0] OP_DIVU  = 5'b10100;
    localparam logic [4:0] OP_REM   = 5'b10101;
    localparam logic [4:0] OP_REMU  = 5'b10110;
    localparam logic [W-1:0] MIN    = 32'h8000_0000;

    localparam logic [4:0] OPS [20] = '{
        5'b00000, 5'b00001, 5'b00010, 5'b00101, 5'b00110,
        5'b00111, 5'b01000, 5'b01010, 5'b01100, 5'b10000,
        5'b10001, 5'b10010, 5'b10011, 5'b10100, 5'b10101,
        5'b10110, 5'b00011, 5'b10111, 5'b11000, 5'b01111
    };

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready, out_valid, Zero;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic [W-1:0] ALUResult;
    logic [4:0]   Operation = '0;

    int vectors = 0;
    int miscompares = 0;

    alu_seq #(
        .DATA_WIDTH   (32),
        .OPCODE_LENGTH(5),
        .ENABLE_M     (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .Operation(Operation),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ALUResult(ALUResult),
        .Zero     (Zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic logic is_mop(input logic [4:0] op);
        return op inside {OP_MUL, OP_MULH, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic int mlat(input logic [4:0] op);
        return is_mop(op) ? 33 : 1;
    endfunction

    function automatic logic [W-1:0] model(input logic [4:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint     sp;
        logic [63:0] up;
        int         sh;
        sh = int'(b[4:0]);
        case (op)
            OP_AND:   return a & b;
            OP_XOR:   return a ^ b;
            OP_ADD:   return a + b;
            OP_OR:    return a | b;
            OP_SLL:   return a << sh;
            OP_SRA:   return $signed(a) >>> sh;
            OP_EQ:    return (a == b) ? 32'd1 : 32'd0;
            OP_SUB:   return a - b;
            OP_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_MUL:   return a * b;
            OP_MULH: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp[63:32];
            end
            OP_MULHU: begin
                up = {32'd0, a} * {32'd0, b};
                return up[63:32];
            end
            OP_DIV: begin
                if (b == '0) return '1;
                if (a == MIN && b == '1) return MIN;
                return $signed(a) / $signed(b);
            end
            OP_DIVU:  return (b == '0) ? '1 : a / b;
            OP_REM: begin
                if (b == '0) return a;
                if (a == MIN && b == '1) return '0;
                return $signed(a) % $signed(b);
            end
            OP_REMU:  return (b == '0) ? a : a % b;
            default:  return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return MIN;
            3:       return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [W-1:0] res;
        int           due;
    } exp_t;

    exp_t q[$];
    int   ncyc = 0;

    // Per-cycle monitor: handshake state, latency and result vs model
    always @(negedge clk) begin
        ncyc++;
        if (reset) begin
            q.delete();
        end else begin
            if (q.size() == 0) begin
                chk("mon_idle_ready", W'(in_ready), 1);
                chk("mon_idle_valid", W'(out_valid), 0);
            end else if (ncyc < q[0].due) begin
                chk("mon_busy_ready", W'(in_ready), 0);
                chk("mon_busy_valid", W'(out_valid), 0);
            end else begin
                chk("mon_done_valid", W'(out_valid), 1);
                chk("mon_done_ready", W'(in_ready), 0);
                chk("mon_result", ALUResult, q[0].res);
                chk("mon_zero", W'(Zero), W'(q[0].res == '0));
                if (out_valid && out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready)
                q.push_back('{model(Operation, SrcA, SrcB), ncyc + mlat(Operation)});
        end
    end

    task automatic issue(input  logic [4:0]   op,
                         input  logic [W-1:0] a,
                         input  logic [W-1:0] b,
                         input  int           hold,
                         output logic [W-1:0] res,
                         output logic         z,
                         output int           lat,
                         output logic [W-1:0] last,
                         output logic         last_rdy);
        int n;
        n = 0;
        res = '0;
        z = 1'b0;
        lat = 0;
        last = '0;
        last_rdy = 1'b0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            timeout_fail("accept_wait");
            return;
        end
        Operation = op;
        SrcA = a;
        SrcB = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        lat = 1;
        while (!out_valid && lat < 100) begin
            in_valid = 1'($urandom);
            SrcA = $urandom;
            SrcB = $urandom;
            Operation = 5'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) timeout_fail("result_wait");
        res = ALUResult;
        z = Zero;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            SrcA = $urandom;
            @(posedge clk);
            #1;
        end
        last = ALUResult;
        last_rdy = in_ready;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r, last, a, b;
        logic         z, lrdy;
        int           lat;
        logic [4:0]   op;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_result", ALUResult, 0);
        chk("rst_zero", W'(Zero), 1);
        chk("rst_in_ready", W'(in_ready), 1);
        chk("rst_out_valid", W'(out_valid), 0);

        chk("pin_div", model(OP_DIV, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFD);
        chk("pin_rem", model(OP_REM, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFF);
        chk("pin_mulhu", model(OP_MULHU, '1, '1), 32'hFFFF_FFFE);
        chk("pin_sra", model(OP_SRA, MIN, 32'h24), 32'hF800_0000);

        issue(OP_ADD, 7, 5, 0, r, z, lat, last, lrdy);
        chk("T1_add", r, 12);
        chk("T1_add_zero", W'(z), 0);
        chk("T1_add_lat", W'(lat), 1);
        issue(OP_SUB, 5, 5, 0, r, z, lat, last, lrdy);
        chk("T1_sub", r, 0);
        chk("T1_sub_zero", W'(z), 1);

        issue(OP_SRA, MIN, 32'h24, 0, r, z, lat, last, lrdy);
        chk("T2_sra", r, 32'hF800_0000);
        issue(OP_SLT, '1, 1, 0, r, z, lat, last, lrdy);
        chk("T2_slt", r, 1);
        issue(OP_SLL, 1, 31, 0, r, z, lat, last, lrdy);
        chk("T2_sll", r, 32'h8000_0000);

        issue(OP_MUL, '1, '1, 0, r, z, lat, last, lrdy);
        chk("T3_mul", r, 1);
        chk("T3_mul_lat", W'(lat), 33);
        issue(OP_MULH, '1, '1, 0, r, z, lat, last, lrdy);
        chk("T3_mulh", r, 0);
        issue(OP_MULHU, '1, '1, 0, r, z, lat, last, lrdy);
        chk("T3_mulhu", r, 32'hFFFF_FFFE);
        chk("T3_mulhu_lat", W'(lat), 33);

        issue(OP_DIV, 32'hFFFF_FFF9, 2, 0, r, z, lat, last, lrdy);
        chk("T4_div", r, 32'hFFFF_FFFD);
        issue(OP_REM, 32'hFFFF_FFF9, 2, 0, r, z, lat, last, lrdy);
        chk("T4_rem", r, 32'hFFFF_FFFF);
        issue(OP_DIVU, 7, 0, 0, r, z, lat, last, lrdy);
        chk("T4_divu_by0", r, 32'hFFFF_FFFF);
        chk("T4_divu_by0_lat", W'(lat), 33);
        issue(OP_REMU, 7, 0, 0, r, z, lat, last, lrdy);
        chk("T4_remu_by0", r, 7);
        issue(OP_DIV, MIN, '1, 0, r, z, lat, last, lrdy);
        chk("T4_div_ovf", r, MIN);
        issue(OP_REM, MIN, '1, 0, r, z, lat, last, lrdy);
        chk("T4_rem_ovf", r, 0);
        chk("T4_rem_ovf_zero", W'(z), 1);

        issue(OP_XOR, 32'h0F0F_0000, 32'h00FF_00FF, 10, r, z, lat, last, lrdy);
        chk("T5_first", r, 32'h0FF0_00FF);
        chk("T5_held", last, 32'h0FF0_00FF);
        chk("T5_held_in_ready", W'(lrdy), 0);
        chk("T5_idle_after", W'(in_ready), 1);

        Operation = OP_MUL;
        SrcA = 32'd1234;
        SrcB = 32'd5678;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("T6_out_valid", W'(out_valid), 0);
        chk("T6_in_ready", W'(in_ready), 1);
        chk("T6_result", ALUResult, 0);
        chk("T6_zero", W'(Zero), 1);
        issue(OP_ADD, 3, 4, 0, r, z, lat, last, lrdy);
        chk("T6_add_after", r, 7);

        for (int i = 0; i < 200; i++) begin
            op = OPS[$urandom_range(0, 19)];
            a = rnd_opnd();
            b = ($urandom_range(0, 7) == 0) ? a : rnd_opnd();
            issue(op, a, b, $urandom_range(0, 2), r, z, lat, last, lrdy);
            chk("rnd_lat", W'(lat), W'(mlat(op)));
        end

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
